// File: rtl/t5_pkg.sv
// t5_pkg: constants shared by the t5 memory stage.
//   - Opcode values (instruction bits [6:2]) for LOAD / STORE and the
//     opcode presented downstream after reset.
//   - Funct3 access-size / extension encodings.
//   - LSU bus FSM state type.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;
  localparam logic [4:0] OPC_RESET = 5'h0D;

  localparam logic [2:0] FN3_B  = 3'd0;
  localparam logic [2:0] FN3_H  = 3'd1;
  localparam logic [2:0] FN3_W  = 3'd2;
  localparam logic [2:0] FN3_BU = 3'd4;
  localparam logic [2:0] FN3_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/t5_lsu_align.sv
// t5_lsu_align: combinational byte-lane / alignment / load-extension helper.
//   fn3   in  3   access funct3 (size in [1:0], unsigned in [2])
//   off   in  2   byte offset within the word
//   dat_i in  32  bus read data
//   sel   out 4   byte-lane select
//   mis   out 1   access is misaligned for its size
//   ldat  out 32  extracted, sign/zero-extended load data (0 for fn3 3/6/7)
module t5_lsu_align
  import t5_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  off,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel,
  output logic        mis,
  output logic [31:0] ldat
);

  logic [31:0] lane;

  always_comb begin
    sel  = '0;
    mis  = 1'b0;
    ldat = '0;
    lane = dat_i >> {off, 3'b000};

    case (fn3[1:0])
      2'b00: sel = 4'b0001 << off;
      2'b01: begin
        sel = off[1] ? 4'b1100 : 4'b0011;
        mis = off[0];
      end
      2'b10: begin
        sel = '1;
        mis = (off != 2'b00);
      end
      default: sel = '0;
    endcase

    case (fn3)
      FN3_B:   ldat = {{24{lane[7]}}, lane[7:0]};
      FN3_H:   ldat = {{16{lane[15]}}, lane[15:0]};
      FN3_W:   ldat = lane;
      FN3_BU:  ldat = {24'h0, lane[7:0]};
      FN3_HU:  ldat = {16'h0, lane[15:0]};
      default: ldat = '0;
    endcase
  end

endmodule

// File: rtl/t5_lsu.sv
// t5_lsu: memory stage. One single-beat stb/ack bus transaction per aligned
// LOAD/STORE, registered writeback to the next stage, stall to the enable
// generator.
//   sclk/srst        clock (rising) / async active-low reset
//   sena             global pipeline enable
//   xopc/xfn3        execute-stage opcode [6:2] / funct3
//   xbpc/xoff        effective word address / byte offset
//   xdat/malu        lane-replicated store data / non-memory result
//   dwb_*            data bus (stb/ack handshake)
//   mstall           stall request
//   mwb/mopc/mfn3    registered writeback, opcode, funct3
//   mmis             {load_misaligned, store_misaligned} pulse
//   mflt             bus watchdog fault pulse
// Optional: define T5_LSU_TIMEOUT_EN to enable the TMO-cycle bus watchdog;
// otherwise BUSY waits for ack indefinitely and mflt stays 0.
module t5_lsu
  import t5_pkg::*;
#(
  parameter int unsigned TMO = 16
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        sena,
  input  logic [4:0]  xopc,
  input  logic [2:0]  xfn3,
  input  logic [29:0] xbpc,
  input  logic [1:0]  xoff,
  input  logic [31:0] xdat,
  input  logic [31:0] malu,
  input  logic        dwb_ack_i,
  input  logic [31:0] dwb_dat_i,
  output logic        dwb_stb_o,
  output logic        dwb_we_o,
  output logic [29:0] dwb_adr_o,
  output logic [3:0]  dwb_sel_o,
  output logic [31:0] dwb_dat_o,
  output logic        mstall,
  output logic [31:0] mwb,
  output logic [4:0]  mopc,
  output logic [2:0]  mfn3,
  output logic [1:0]  mmis,
  output logic        mflt
);

  if (TMO < 2) begin : g_tmo_chk
    $error("t5_lsu: TMO must be at least 2");
  end

  lsu_state_e  state_q, state_d;
  logic        stb_q, stb_d, we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] mwb_q, mwb_d;
  logic [4:0]  mopc_q, mopc_d;
  logic [2:0]  mfn3_q, mfn3_d;
  logic [1:0]  mmis_q, mmis_d;
  logic        mflt_q, mflt_d;
  // Result of a transaction that finished while sena was low.
  logic        pend_q, pend_d;
  logic [31:0] pwb_q, pwb_d;
  logic        pflt_q, pflt_d;

  logic        is_load, is_store, is_mem;
  logic [3:0]  sel_w;
  logic        mis_w;
  logic [31:0] ldat_w;
  logic        tmo_hit;
  logic        upd;
  logic [31:0] nwb;
  logic [1:0]  nmis;
  logic        nflt;

  assign is_load  = (xopc == OPC_LOAD);
  assign is_store = (xopc == OPC_STORE);
  assign is_mem   = is_load | is_store;

  t5_lsu_align u_align (
    .fn3   (xfn3),
    .off   (xoff),
    .dat_i (dwb_dat_i),
    .sel   (sel_w),
    .mis   (mis_w),
    .ldat  (ldat_w)
  );

`ifdef T5_LSU_TIMEOUT_EN
  localparam int unsigned CW = (TMO > 2) ? $clog2(TMO) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == LSU_BUSY) && !dwb_ack_i && (cnt_q == CW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LSU_IDLE)
      cnt_d = '0;
    else if (!dwb_ack_i && !tmo_hit)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    mwb_d   = mwb_q;
    mopc_d  = mopc_q;
    mfn3_d  = mfn3_q;
    mmis_d  = mmis_q;
    mflt_d  = mflt_q;
    pend_d  = pend_q;
    pwb_d   = pwb_q;
    pflt_d  = pflt_q;
    mstall  = 1'b0;
    upd     = 1'b0;
    nwb     = '0;
    nmis    = '0;
    nflt    = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        // A buffered result is committed before any new request; the
        // upstream stage is still presenting the same memory instruction.
        if (pend_q) begin
          if (sena) begin
            upd    = 1'b1;
            nwb    = pwb_q;
            nflt   = pflt_q;
            pend_d = 1'b0;
          end
        end else if (sena && is_mem) begin
          if (mis_w) begin
            upd  = 1'b1;
            nmis = {is_load, is_store};
          end else begin
            mstall  = 1'b1;
            state_d = LSU_BUSY;
            stb_d   = 1'b1;
            we_d    = is_store;
            adr_d   = xbpc;
            sel_d   = sel_w;
            dat_d   = xdat;
          end
        end else if (sena) begin
          upd = 1'b1;
          nwb = malu;
        end
      end

      LSU_BUSY: begin
        if (dwb_ack_i || tmo_hit) begin
          state_d = LSU_IDLE;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          nwb     = (dwb_ack_i && !we_q) ? ldat_w : '0;
          nflt    = !dwb_ack_i;
          if (sena) begin
            upd = 1'b1;
          end else begin
            pend_d = 1'b1;
            pwb_d  = nwb;
            pflt_d = nflt;
          end
        end else begin
          mstall = 1'b1;
        end
      end

      default: state_d = LSU_IDLE;
    endcase

    if (upd) begin
      mwb_d  = nwb;
      mopc_d = xopc;
      mfn3_d = xfn3;
      mmis_d = nmis;
      mflt_d = nflt;
    end
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= LSU_IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      mwb_q   <= '0;
      mopc_q  <= OPC_RESET;
      mfn3_q  <= '0;
      mmis_q  <= '0;
      mflt_q  <= 1'b0;
      pend_q  <= 1'b0;
      pwb_q   <= '0;
      pflt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      mwb_q   <= mwb_d;
      mopc_q  <= mopc_d;
      mfn3_q  <= mfn3_d;
      mmis_q  <= mmis_d;
      mflt_q  <= mflt_d;
      pend_q  <= pend_d;
      pwb_q   <= pwb_d;
      pflt_q  <= pflt_d;
    end
  end

  assign dwb_stb_o = stb_q;
  assign dwb_we_o  = we_q;
  assign dwb_adr_o = adr_q;
  assign dwb_sel_o = sel_q;
  assign dwb_dat_o = dat_q;
  assign mwb       = mwb_q;
  assign mopc      = mopc_q;
  assign mfn3      = mfn3_q;
  assign mmis      = mmis_q;
  assign mflt      = mflt_q;

endmodule

// File: tb/tb_t5_lsu.sv
module tb_t5_lsu;
  import t5_pkg::*;

  logic        sclk = 1'b0;
  logic        srst;
  logic        sena;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [29:0] xbpc;
  logic [1:0]  xoff;
  logic [31:0] xdat;
  logic [31:0] malu;
  logic        dwb_ack_i;
  logic [31:0] dwb_dat_i;
  logic        dwb_stb_o;
  logic        dwb_we_o;
  logic [29:0] dwb_adr_o;
  logic [3:0]  dwb_sel_o;
  logic [31:0] dwb_dat_o;
  logic        mstall;
  logic [31:0] mwb;
  logic [4:0]  mopc;
  logic [2:0]  mfn3;
  logic [1:0]  mmis;
  logic        mflt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  t5_lsu #(.TMO(16)) dut (
    .sclk      (sclk),
    .srst      (srst),
    .sena      (sena),
    .xopc      (xopc),
    .xfn3      (xfn3),
    .xbpc      (xbpc),
    .xoff      (xoff),
    .xdat      (xdat),
    .malu      (malu),
    .dwb_ack_i (dwb_ack_i),
    .dwb_dat_i (dwb_dat_i),
    .dwb_stb_o (dwb_stb_o),
    .dwb_we_o  (dwb_we_o),
    .dwb_adr_o (dwb_adr_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_dat_o (dwb_dat_o),
    .mstall    (mstall),
    .mwb       (mwb),
    .mopc      (mopc),
    .mfn3      (mfn3),
    .mmis      (mmis),
    .mflt      (mflt)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  fn3;
    logic [1:0]  off;
    logic [29:0] bpc;
    logic [31:0] xd;
    logic [31:0] alu;
    logic [31:0] rdata;
    int unsigned wt;
    logic        go;
    logic [3:0]  esel;
    logic        ewe;
    logic [31:0] ewb;
    logic [1:0]  emis;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] opc, input logic [2:0] fn3,
                              input logic [1:0] off, input logic [29:0] bpc,
                              input logic [31:0] xd, input logic [31:0] alu,
                              input logic [31:0] rdata, input int unsigned wt,
                              input logic go, input logic [3:0] esel, input logic ewe,
                              input logic [31:0] ewb, input logic [1:0] emis);
    vec_t v;
    v.opc = opc; v.fn3 = fn3; v.off = off; v.bpc = bpc; v.xd = xd; v.alu = alu;
    v.rdata = rdata; v.wt = wt; v.go = go; v.esel = esel; v.ewe = ewe;
    v.ewb = ewb; v.emis = emis;
    return v;
  endfunction

  // Reference: access size in bytes, alignment by modulo, lanes as a run of
  // size bytes starting at the offset, extension by numeric range.
  function automatic vec_t model(input vec_t vin);
    vec_t v = vin;
    int unsigned sz, offi;
    logic [31:0] lane, b, h;
    logic [1:0] szc;
    szc  = v.fn3[1:0];
    sz   = 1 << szc;
    offi = v.off;
    v.go = 1'b0; v.esel = 4'h0; v.ewe = 1'b0; v.emis = 2'b00; v.ewb = v.alu;
    if (v.opc == 5'h00 || v.opc == 5'h08) begin
      v.ewb = 32'h0;
      if ((offi % sz) != 0) begin
        v.emis = (v.opc == 5'h00) ? 2'b10 : 2'b01;
      end else begin
        v.go   = 1'b1;
        v.ewe  = (v.opc == 5'h08);
        v.esel = 4'(((1 << sz) - 1) << offi);
        if (v.opc == 5'h00) begin
          lane = v.rdata >> (8 * offi);
          b = lane % 256;
          h = lane % 65536;
          case (v.fn3)
            3'd0: v.ewb = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: v.ewb = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2: v.ewb = v.rdata;
            3'd4: v.ewb = b;
            3'd5: v.ewb = h;
            default: v.ewb = 32'h0;
          endcase
        end
      end
    end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    sena = 1'b1; xopc = v.opc; xfn3 = v.fn3; xoff = v.off; xbpc = v.bpc;
    xdat = v.xd; malu = v.alu; dwb_ack_i = 1'b0; dwb_dat_i = 32'h0;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    @(negedge sclk);
    drive(v);
    #1;
    chk({nm, "_mstall_issue"}, 32'(mstall), 32'(v.go));
    @(posedge sclk); #1;
    chk({nm, "_stb"}, 32'(dwb_stb_o), 32'(v.go));
    if (v.go) begin
      for (int unsigned c = 0; c <= v.wt; c++) begin
        @(negedge sclk);
        chk({nm, "_adr"}, 32'(dwb_adr_o), 32'(v.bpc));
        chk({nm, "_stb_hold"}, 32'(dwb_stb_o), 32'd1);
        if (c == 0) begin
          chk({nm, "_sel"}, 32'(dwb_sel_o), 32'(v.esel));
          chk({nm, "_we"}, 32'(dwb_we_o), 32'(v.ewe));
          if (v.ewe) chk({nm, "_dat_o"}, dwb_dat_o, v.xd);
        end
        if (c == v.wt) begin
          dwb_ack_i = 1'b1;
          dwb_dat_i = v.rdata;
          #1 chk({nm, "_mstall_ack"}, 32'(mstall), 32'd0);
        end else begin
          #1 chk({nm, "_mstall_wait"}, 32'(mstall), 32'd1);
        end
        @(posedge sclk); #1;
      end
      chk({nm, "_stb_drop"}, 32'(dwb_stb_o), 32'd0);
      chk({nm, "_we_drop"}, 32'(dwb_we_o), 32'd0);
    end
    chk({nm, "_mwb"}, mwb, v.ewb);
    chk({nm, "_mopc"}, 32'(mopc), 32'(v.opc));
    chk({nm, "_mfn3"}, 32'(mfn3), 32'(v.fn3));
    chk({nm, "_mmis"}, 32'(mmis), 32'(v.emis));
    chk({nm, "_mflt"}, 32'(mflt), 32'd0);
  endtask

  vec_t tab[10];
  vec_t rv;
  int unsigned n;

  initial begin
    srst = 1'b0; sena = 1'b0; xopc = 5'h04; xfn3 = 3'd0; xbpc = '0; xoff = '0;
    xdat = '0; malu = '0; dwb_ack_i = 1'b0; dwb_dat_i = '0;

    //            opc    fn3 off bpc       xdat           malu           rdata         wt go sel    we ewb            mis
    tab[0] = mk(5'h00, 3'd0, 2'd3, 30'h10,  32'h0,         32'h0,         32'h80AB_CDEF, 0, 1, 4'b1000, 0, 32'hFFFF_FF80, 2'b00);
    tab[1] = mk(5'h00, 3'd5, 2'd2, 30'h24,  32'h0,         32'h0,         32'h8001_1234, 3, 1, 4'b1100, 0, 32'h0000_8001, 2'b00);
    tab[2] = mk(5'h08, 3'd2, 2'd0, 30'h100, 32'hDEAD_BEEF, 32'h0,         32'h0,         1, 1, 4'b1111, 1, 32'h0,         2'b00);
    tab[3] = mk(5'h00, 3'd2, 2'd2, 30'h8,   32'h0,         32'h0,         32'h0,         0, 0, 4'b0000, 0, 32'h0,         2'b10);
    tab[4] = mk(5'h08, 3'd1, 2'd1, 30'h8,   32'h0,         32'h0,         32'h0,         0, 0, 4'b0000, 0, 32'h0,         2'b01);
    tab[5] = mk(5'h04, 3'd0, 2'd0, 30'h0,   32'h0,         32'h1234_5678, 32'h0,         0, 0, 4'b0000, 0, 32'h1234_5678, 2'b00);
    tab[6] = mk(5'h00, 3'd1, 2'd0, 30'h3,   32'h0,         32'h0,         32'h0000_8765, 2, 1, 4'b0011, 0, 32'hFFFF_8765, 2'b00);
    tab[7] = mk(5'h00, 3'd4, 2'd1, 30'h4,   32'h0,         32'h0,         32'h0000_FF00, 0, 1, 4'b0010, 0, 32'h0000_00FF, 2'b00);
    tab[8] = mk(5'h08, 3'd0, 2'd2, 30'h5,   32'h5A5A_5A5A, 32'h0,         32'h0,         0, 1, 4'b0100, 1, 32'h0,         2'b00);
    tab[9] = mk(5'h08, 3'd1, 2'd2, 30'h6,   32'h3C3C_3C3C, 32'h0,         32'h0,         1, 1, 4'b1100, 1, 32'h0,         2'b00);

    // reset values
    #12;
    chk("rst_stb", 32'(dwb_stb_o), 32'd0);
    chk("rst_mwb", mwb, 32'h0);
    chk("rst_mopc", 32'(mopc), 32'h0D);
    chk("rst_mmis_mflt", {29'h0, mmis, mflt}, 32'h0);
    @(negedge sclk); srst = 1'b1;

    foreach (tab[i]) run_op(tab[i], $sformatf("vec%0d", i));

    // sena low: output registers hold
    @(negedge sclk);
    sena = 1'b0; xopc = 5'h0C; malu = 32'hAAAA_5555;
    @(posedge sclk); #1;
    chk("hold_mwb", mwb, 32'h0000_0000);
    chk("hold_mopc", 32'(mopc), 32'h08);

    // ack while IDLE is ignored
    rv = mk(5'h0C, 3'd3, 2'd0, 30'h0, 32'h0, 32'h1111_2222, 32'h0, 0, 0, 4'h0, 0, 32'h1111_2222, 2'b00);
    @(negedge sclk); drive(rv); dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFF_FFFF;
    @(posedge sclk); #1;
    chk("idle_ack_stb", 32'(dwb_stb_o), 32'd0);
    chk("idle_ack_mwb", mwb, 32'h1111_2222);

    // sena drops while BUSY: result buffered, committed once sena returns
    rv = mk(5'h00, 3'd2, 2'd0, 30'h77, 32'h0, 32'h0, 32'h0, 0, 1, 4'hF, 0, 32'h0, 2'b00);
    @(negedge sclk); drive(rv);
    @(posedge sclk); #1;
    @(negedge sclk); sena = 1'b0; dwb_ack_i = 1'b1; dwb_dat_i = 32'hCAFE_F00D;
    #1 chk("pend_mstall_ack", 32'(mstall), 32'd0);
    @(posedge sclk); #1;
    chk("pend_stb_drop", 32'(dwb_stb_o), 32'd0);
    chk("pend_mwb_hold", mwb, 32'h1111_2222);
    @(negedge sclk); dwb_ack_i = 1'b0;
    @(posedge sclk); #1;
    chk("pend_mwb_hold2", mwb, 32'h1111_2222);
    @(negedge sclk); sena = 1'b1;
    #1 chk("pend_commit_mstall", 32'(mstall), 32'd0);
    @(posedge sclk); #1;
    chk("pend_commit_mwb", mwb, 32'hCAFE_F00D);
    chk("pend_no_reissue", 32'(dwb_stb_o), 32'd0);

`ifdef T5_LSU_TIMEOUT_EN
    rv = mk(5'h00, 3'd2, 2'd0, 30'h55, 32'h0, 32'h0, 32'h0, 0, 1, 4'hF, 0, 32'h0, 2'b00);
    @(negedge sclk); drive(rv);
    @(posedge sclk); #1;
    n = 0;
    while (dwb_stb_o && n < 40) begin
      n++;
      @(posedge sclk); #1;
    end
    chk("tmo_stb_cycles", n, 32'd16);
    chk("tmo_mflt", 32'(mflt), 32'd1);
    chk("tmo_mwb", mwb, 32'h0);
    rv = mk(5'h04, 3'd0, 2'd0, 30'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 0, 4'h0, 0, 32'h0BAD_F00D, 2'b00);
    run_op(rv, "tmo_clear");
`else
    rv = model(mk(5'h00, 3'd2, 2'd0, 30'h55, 32'h0, 32'h0, 32'h7654_3210, 40, 0, 4'h0, 0, 32'h0, 2'b00));
    run_op(rv, "long_wait");
`endif

    // randomized against the reference model
    for (int k = 0; k < 150; k++) begin
      int unsigned sel_op;
      sel_op = $urandom_range(0, 2);
      rv.opc = (sel_op == 0) ? 5'h00 : (sel_op == 1) ? 5'h08 : 5'h04 + 5'($urandom_range(0, 3) * 8 + 1);
      case (sel_op)
        0: begin
          int unsigned f;
          f = $urandom_range(0, 4);
          rv.fn3 = (f < 3) ? 3'(f) : 3'(f + 1);
        end
        1: rv.fn3 = 3'($urandom_range(0, 2));
        default: rv.fn3 = 3'($urandom_range(0, 7));
      endcase
      rv.off   = 2'($urandom_range(0, 3));
      rv.bpc   = 30'($urandom);
      rv.xd    = $urandom;
      rv.alu   = $urandom;
      rv.rdata = $urandom;
      rv.wt    = $urandom_range(0, 3);
      rv = model(rv);
      run_op(rv, $sformatf("rnd%0d", k));
    end

    // reset in mid-transaction abandons it
    rv = mk(5'h08, 3'd2, 2'd0, 30'h3FF, 32'h1357_9BDF, 32'h0, 32'h0, 0, 1, 4'hF, 1, 32'h0, 2'b00);
    @(negedge sclk); drive(rv);
    @(posedge sclk); #1;
    chk("rmid_busy_stb", 32'(dwb_stb_o), 32'd1);
    @(negedge sclk); sena = 1'b0; srst = 1'b0;
    #1;
    chk("rmid_stb", 32'(dwb_stb_o), 32'd0);
    chk("rmid_we", 32'(dwb_we_o), 32'd0);
    chk("rmid_adr_sel", {dwb_adr_o, dwb_sel_o[1:0]}, 32'h0);
    chk("rmid_sel_hi", 32'(dwb_sel_o), 32'h0);
    chk("rmid_dat", dwb_dat_o, 32'h0);
    chk("rmid_mwb", mwb, 32'h0);
    chk("rmid_mopc", 32'(mopc), 32'h0D);
    chk("rmid_mfn3_mmis_mflt", {26'h0, mfn3, mmis, mflt}, 32'h0);
    @(negedge sclk); srst = 1'b1;
    @(posedge sclk); #1;
    chk("rmid_after_stb", 32'(dwb_stb_o), 32'd0);
    rv = mk(5'h04, 3'd0, 2'd0, 30'h0, 32'h0, 32'h2468_ACE0, 32'h0, 0, 0, 4'h0, 0, 32'h2468_ACE0, 2'b00);
    run_op(rv, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
